// File: rtl/inst_sequencer.sv
// ---------------------------------------------------------------------------
// inst_sequencer
//
// Produces the 35-bit instruction word for the accelerator core. A single
// start pulse runs one weight-stationary pass:
//   - read col weight vectors from SRAM0 into L0
//   - move them from L0 into the PE array
//   - wait drain idle cycles for the array to settle
//   - read n_x activation vectors from SRAM0 into L0
//   - stream them through the array with execute
//   - copy n_x psum vectors from the OFIFO into SRAM1
// The pass ends with a one-cycle done pulse.
//
// Parameters
//   col     PE columns, which is also the number of weight vectors per tile
//   row     PE rows (informational only)
//   addr_w  SRAM address width; the inst bit map fixes this at 11
//   drain   idle cycles between weight load and activation load (>= 1)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start        one-cycle pass request, honoured only while idle
//   w_base       SRAM0 address of weight vector 0
//   x_base       SRAM0 address of activation vector 0
//   p_base       SRAM1 address of psum vector 0
//   n_x          number of activation vectors (0 skips the execute phases)
//   ofifo_valid  core OFIFO holds a readable psum vector
//   inst         registered instruction word
//   busy         pass in progress (low in IDLE and in the DONE cycle)
//   done         one-cycle completion pulse
//
// inst bit map
//   [34] acc (always 0)   [33] CEN_pmem  [32] WEN_pmem  [31:21] A_pmem
//   [20] CEN_xmem         [19] WEN_xmem  [18:8] A_xmem
//   [7] ofifo_rd  [6] ififo_wr (0)  [5] ififo_rd (0)  [4] l0_rd  [3] l0_wr
//   [2] mode (0)  [1] execute  [0] load
//   CEN and WEN are active-low.
// ---------------------------------------------------------------------------
module inst_sequencer #(
   parameter int col    = 8,
   parameter int row    = 8,
   parameter int addr_w = 11,
   parameter int drain  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [addr_w-1:0] w_base,
   input  logic [addr_w-1:0] x_base,
   input  logic [addr_w-1:0] p_base,
   input  logic [addr_w-1:0] n_x,
   input  logic              ofifo_valid,
   output logic [34:0]       inst,
   output logic              busy,
   output logic              done
);

   // Reject configurations that the fixed inst bit map or the counter cannot
   // represent.
   if (col < 1 || row < 1 || drain < 1 || addr_w != 11) begin : g_bad_cfg
      $error("inst_sequencer: unsupported configuration");
   end

   typedef enum logic [2:0] {
      IDLE,
      LDW_RD,
      LDW_PE,
      DRAIN,
      LDX_RD,
      EXEC,
      ACC,
      DONE
   } state_t;

   // Both SRAMs deselected with write disabled; every other bit is low.
   localparam logic [34:0] IDLE_WORD = 35'h3_0018_0000;

   localparam int BIT_CEN_P  = 33;
   localparam int BIT_WEN_P  = 32;
   localparam int BIT_CEN_X  = 20;
   localparam int BIT_OF_RD  = 7;
   localparam int BIT_L0_RD  = 4;
   localparam int BIT_L0_WR  = 3;
   localparam int BIT_EXEC   = 1;
   localparam int BIT_LOAD   = 0;

   localparam logic [addr_w-1:0] ONE        = addr_w'(1);
   localparam logic [addr_w-1:0] COL_LAST   = addr_w'(col - 1);
   localparam logic [addr_w-1:0] DRAIN_LAST = addr_w'(drain - 1);

   state_t            state;
   state_t            next_state;
   logic [addr_w-1:0] k;
   logic [addr_w-1:0] next_k;
   logic [addr_w-1:0] k_inc;
   logic [addr_w-1:0] nx_last;
   logic [addr_w-1:0] w_base_q;
   logic [addr_w-1:0] x_base_q;
   logic [addr_w-1:0] p_base_q;
   logic [addr_w-1:0] n_x_q;
   logic [addr_w-1:0] w_base_eff;
   logic              rd_pending;
   logic              acc_read_now;

   // Builds the word for the cycle a state is entered or continued. The
   // l0_wr flag is OR-ed in independently of the state because the SRAM0
   // read latency can push it into the first cycle of the next state.
   function automatic logic [34:0] word_of(
      input state_t            st,
      input logic [addr_w-1:0] kk,
      input logic              fifo_valid,
      input logic [addr_w-1:0] wb,
      input logic [addr_w-1:0] xb,
      input logic [addr_w-1:0] pb,
      input logic              l0_wr_flag
   );
      logic [34:0] w;
      w = IDLE_WORD;
      w[BIT_L0_WR] = l0_wr_flag;
      case (st)
         LDW_RD: begin
            w[BIT_CEN_X] = 1'b0;
            w[18:8]      = wb + kk;
         end
         LDW_PE: begin
            w[BIT_L0_RD] = 1'b1;
            w[BIT_LOAD]  = 1'b1;
         end
         LDX_RD: begin
            w[BIT_CEN_X] = 1'b0;
            w[18:8]      = xb + kk;
         end
         EXEC: begin
            w[BIT_L0_RD] = 1'b1;
            w[BIT_EXEC]  = 1'b1;
         end
         ACC: begin
            if (fifo_valid) begin
               w[BIT_OF_RD] = 1'b1;
               w[BIT_CEN_P] = 1'b0;
               w[BIT_WEN_P] = 1'b0;
               w[31:21]     = pb + kk;
            end
         end
         default: begin
         end
      endcase
      return w;
   endfunction

   assign k_inc        = k + ONE;
   assign nx_last      = n_x_q - ONE;
   assign rd_pending   = ~inst[BIT_CEN_X];
   assign acc_read_now = inst[BIT_OF_RD];

   // The first LDW_RD word is built in the same edge that latches the bases,
   // so it has to take w_base straight from the port.
   assign w_base_eff = (state == IDLE) ? w_base : w_base_q;

   // Phase sequencing. Each phase counts k from zero up to its length minus
   // one and clears k when it hands over. ACC counts completed reads rather
   // than cycles, so it advances only on cycles whose word carries ofifo_rd.
   always_comb begin
      next_state = state;
      next_k     = k;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = LDW_RD;
               next_k     = '0;
            end
         end
         LDW_RD: begin
            if (k == COL_LAST) begin
               next_state = LDW_PE;
               next_k     = '0;
            end else begin
               next_k = k_inc;
            end
         end
         LDW_PE: begin
            if (k == COL_LAST) begin
               next_state = DRAIN;
               next_k     = '0;
            end else begin
               next_k = k_inc;
            end
         end
         DRAIN: begin
            if (k == DRAIN_LAST) begin
               next_state = (n_x_q == '0) ? DONE : LDX_RD;
               next_k     = '0;
            end else begin
               next_k = k_inc;
            end
         end
         LDX_RD: begin
            if (k == nx_last) begin
               next_state = EXEC;
               next_k     = '0;
            end else begin
               next_k = k_inc;
            end
         end
         EXEC: begin
            if (k == nx_last) begin
               next_state = ACC;
               next_k     = '0;
            end else begin
               next_k = k_inc;
            end
         end
         ACC: begin
            if (acc_read_now) begin
               if (k_inc == n_x_q) begin
                  next_state = DONE;
                  next_k     = '0;
               end else begin
                  next_k = k_inc;
               end
            end
         end
         DONE: begin
            next_state = IDLE;
            next_k     = '0;
         end
         default: begin
            next_state = IDLE;
            next_k     = '0;
         end
      endcase
   end

   // State, counter, latched pass parameters and all outputs. Outputs are
   // computed from the next state so they line up with it cycle for cycle.
   // ofifo_valid seen this cycle decides whether next cycle's ACC word reads.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         k        <= '0;
         inst     <= IDLE_WORD;
         busy     <= 1'b0;
         done     <= 1'b0;
         w_base_q <= '0;
         x_base_q <= '0;
         p_base_q <= '0;
         n_x_q    <= '0;
      end else begin
         state <= next_state;
         k     <= next_k;
         inst  <= word_of(next_state, next_k, ofifo_valid, w_base_eff,
                          x_base_q, p_base_q, rd_pending);
         busy  <= (next_state != IDLE) && (next_state != DONE);
         done  <= (next_state == DONE);
         if (state == IDLE && start) begin
            w_base_q <= w_base;
            x_base_q <= x_base;
            p_base_q <= p_base;
            n_x_q    <= n_x;
         end
      end
   end

endmodule

// File: tb/tb_inst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_inst_sequencer
//
// Bench for inst_sequencer. A reference model turns the pass parameters and
// the planned ofifo_valid stream into the expected per-cycle list of
// {inst, busy, done}. The model works phase by phase and then overlays l0_wr
// one cycle after every SRAM0 read. A table of directed passes also carries
// hand-derived done cycles and write counts. Randomized passes and a
// mid-pass reset sequence follow.
// ---------------------------------------------------------------------------
module tb_inst_sequencer;

   localparam int COL  = 8;
   localparam int DRN  = 16;
   localparam int MAXC = 256;
   localparam logic [34:0] IDLE_WORD = 35'h3_0018_0000;

   logic        clk;
   logic        reset;
   logic        start;
   logic [10:0] w_base;
   logic [10:0] x_base;
   logic [10:0] p_base;
   logic [10:0] n_x;
   logic        ofifo_valid;
   logic [34:0] inst;
   logic        busy;
   logic        done;

   int vectors;
   int miscompares;

   logic [34:0] exp_inst  [0:MAXC];
   logic        exp_busy  [0:MAXC];
   logic        exp_done  [0:MAXC];
   logic        valid_arr [0:MAXC];
   int          exp_len;

   typedef struct {
      logic [10:0] wb;
      logic [10:0] xb;
      logic [10:0] pb;
      logic [10:0] nx;
      logic [6:0]  vpat;
      int          exp_done_cycle;
      int          exp_writes;
   } vec_t;

   vec_t table_vecs [0:4];

   inst_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .w_base     (w_base),
      .x_base     (x_base),
      .p_base     (p_base),
      .n_x        (n_x),
      .ofifo_valid(ofifo_valid),
      .inst       (inst),
      .busy       (busy),
      .done       (done)
   );

   // 10-time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected trace for one pass started in cycle 0.
   task automatic buildModel(input logic [10:0] wb, input logic [10:0] xb,
                             input logic [10:0] pb, input logic [10:0] nx);
      int          t;
      int          reads;
      logic [34:0] w;
      logic [10:0] a;
      for (int i = 0; i <= MAXC; i++) begin
         exp_inst[i] = IDLE_WORD;
         exp_busy[i] = 1'b0;
         exp_done[i] = 1'b0;
      end
      t = 1;
      for (int i = 0; i < COL; i++) begin
         w = IDLE_WORD; a = wb + 11'(i); w[20] = 1'b0; w[18:8] = a;
         exp_inst[t] = w; exp_busy[t] = 1'b1; t++;
      end
      for (int i = 0; i < COL; i++) begin
         w = IDLE_WORD; w[4] = 1'b1; w[0] = 1'b1;
         exp_inst[t] = w; exp_busy[t] = 1'b1; t++;
      end
      for (int i = 0; i < DRN; i++) begin
         exp_busy[t] = 1'b1; t++;
      end
      if (nx != 11'd0) begin
         for (int i = 0; i < int'(nx); i++) begin
            w = IDLE_WORD; a = xb + 11'(i); w[20] = 1'b0; w[18:8] = a;
            exp_inst[t] = w; exp_busy[t] = 1'b1; t++;
         end
         for (int i = 0; i < int'(nx); i++) begin
            w = IDLE_WORD; w[4] = 1'b1; w[1] = 1'b1;
            exp_inst[t] = w; exp_busy[t] = 1'b1; t++;
         end
         reads = 0;
         while (reads < int'(nx) && t < MAXC - 4) begin
            w = IDLE_WORD;
            if (valid_arr[t-1]) begin
               a = pb + 11'(reads);
               w[7] = 1'b1; w[33] = 1'b0; w[32] = 1'b0; w[31:21] = a;
               reads++;
            end
            exp_inst[t] = w; exp_busy[t] = 1'b1; t++;
         end
      end
      exp_done[t] = 1'b1;
      exp_len = t;
      for (int i = 2; i <= MAXC; i++) begin
         if (exp_inst[i-1][20] == 1'b0) exp_inst[i][3] = 1'b1;
      end
   endtask

   // ofifo_valid plan: the repeating pattern starts in the last EXEC cycle,
   // so its first bit decides the first ACC cycle.
   task automatic fillValid(input logic [10:0] nx, input logic [6:0] vpat,
                            input bit use_pat);
      int pre;
      pre = 2 * COL + DRN + 2 * int'(nx);
      for (int t = 0; t <= MAXC; t++) begin
         if (use_pat && t >= pre) valid_arr[t] = vpat[(t - pre) % 7];
         else if (t >= pre + 30)  valid_arr[t] = 1'b1;
         else                     valid_arr[t] = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic checkOutput(input string tag, input int t,
                              input logic [34:0] ei, input logic eb,
                              input logic ed);
      vectors++;
      if (inst !== ei || busy !== eb || done !== ed) begin
         miscompares++;
         $display("[TB] FAIL %s cycle %0d: got inst=%h busy=%b done=%b, want inst=%h busy=%b done=%b",
                  tag, t, inst, busy, done, ei, eb, ed);
      end
   endtask

   task automatic checkCount(input string tag, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, want %0d", tag, got, want);
      end
   endtask

   // Runs one pass from an idle DUT, called #1 after a rising edge. With
   // noise set, start is pulsed at random and the base inputs are scrambled
   // while the pass runs; neither may affect the sequence.
   task automatic applyStimulus(input string tag, input logic [10:0] wb,
                                input logic [10:0] xb, input logic [10:0] pb,
                                input logic [10:0] nx, input bit noise,
                                output int done_cycle, output int writes);
      buildModel(wb, xb, pb, nx);
      w_base = wb; x_base = xb; p_base = pb; n_x = nx;
      start = 1'b1; ofifo_valid = valid_arr[0];
      done_cycle = -1; writes = 0;
      for (int t = 1; t <= exp_len + 2; t++) begin
         @(posedge clk); #1;
         checkOutput(tag, t, exp_inst[t], exp_busy[t], exp_done[t]);
         if (done === 1'b1 && done_cycle < 0) done_cycle = t;
         if (inst[33] === 1'b0) writes++;
         start = (noise && t <= exp_len) ? ($urandom_range(0, 3) == 0) : 1'b0;
         ofifo_valid = valid_arr[t];
         if (noise && t <= exp_len) begin
            w_base = 11'($urandom); x_base = 11'($urandom);
            p_base = 11'($urandom); n_x = 11'($urandom);
         end
      end
   endtask

   initial begin
      int dc;
      int wr;
      logic [10:0] rnx;

      vectors = 0;
      miscompares = 0;
      reset = 1'b0; start = 1'b0; ofifo_valid = 1'b0;
      w_base = '0; x_base = '0; p_base = '0; n_x = '0;

      table_vecs[0] = '{11'h000, 11'h040, 11'h100, 11'd4, 7'h7F, 45, 4};
      table_vecs[1] = '{11'h000, 11'h040, 11'h100, 11'd4, 7'h59, 48, 4};
      table_vecs[2] = '{11'h000, 11'h040, 11'h100, 11'd0, 7'h7F, 33, 0};
      table_vecs[3] = '{11'h7FC, 11'h040, 11'h100, 11'd4, 7'h7F, 45, 4};
      table_vecs[4] = '{11'h010, 11'h7FE, 11'h7FD, 11'd3, 7'h55, 44, 3};

      // Reset held for three cycles with random inputs.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checkOutput("reset_hold", i, IDLE_WORD, 1'b0, 1'b0);
         start = 1'($urandom_range(0, 1)); ofifo_valid = 1'($urandom_range(0, 1));
         w_base = 11'($urandom); x_base = 11'($urandom);
         p_base = 11'($urandom); n_x = 11'($urandom);
      end
      start = 1'b0;
      #2 reset = 1'b1;
      @(posedge clk); #1;
      checkOutput("after_reset", 0, IDLE_WORD, 1'b0, 1'b0);

      // Directed table of passes.
      for (int v = 0; v < 5; v++) begin
         fillValid(table_vecs[v].nx, table_vecs[v].vpat, 1'b1);
         applyStimulus($sformatf("table%0d", v), table_vecs[v].wb,
                       table_vecs[v].xb, table_vecs[v].pb, table_vecs[v].nx,
                       1'b1, dc, wr);
         checkCount($sformatf("table%0d done_cycle", v), dc,
                    table_vecs[v].exp_done_cycle);
         checkCount($sformatf("table%0d pmem_writes", v), wr,
                    table_vecs[v].exp_writes);
      end

      // Reset asserted in the middle of EXEC, then a fresh pass.
      fillValid(11'd4, 7'h7F, 1'b1);
      buildModel(11'h000, 11'h040, 11'h100, 11'd4);
      w_base = 11'h000; x_base = 11'h040; p_base = 11'h100; n_x = 11'd4;
      start = 1'b1; ofifo_valid = 1'b1;
      for (int t = 1; t <= 38; t++) begin
         @(posedge clk); #1;
         checkOutput("pre_reset", t, exp_inst[t], exp_busy[t], exp_done[t]);
         start = 1'b0;
      end
      #2 reset = 1'b0;
      #1 checkOutput("async_reset", 38, IDLE_WORD, 1'b0, 1'b0);
      @(posedge clk); #1;
      checkOutput("reset_held", 39, IDLE_WORD, 1'b0, 1'b0);
      #2 reset = 1'b1;
      @(posedge clk); #1;
      checkOutput("reset_release", 0, IDLE_WORD, 1'b0, 1'b0);
      applyStimulus("post_reset", 11'h123, 11'h040, 11'h100, 11'd4, 1'b0, dc, wr);
      checkCount("post_reset done_cycle", dc, 45);

      // Randomized passes against the model.
      for (int r = 0; r < 12; r++) begin
         rnx = 11'($urandom_range(0, 6));
         fillValid(rnx, 7'h00, 1'b0);
         applyStimulus($sformatf("rand%0d", r), 11'($urandom), 11'($urandom),
                       11'($urandom), rnx, 1'b1, dc, wr);
         checkCount($sformatf("rand%0d done_cycle", r), dc, exp_len);
         checkCount($sformatf("rand%0d pmem_writes", r), wr, int'(rnx));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
